// File: rtl/i3c_sda_drive_ctrl_if.sv
// i3c_sda_drive_ctrl_if: command handshake, timing configuration and
// driver-cell enables between the bus FSMs and the SDA/SCL drive controller.
// master = bus FSM side, slave = drive controller side.
interface i3c_sda_drive_ctrl_if #(
  parameter int DeadTimeW = 4,
  parameter int HandoffW  = 8
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [1:0]           cmd_i;
  logic                 cmd_pp_i;
  logic [DeadTimeW-1:0] dead_time_i;
  logic [HandoffW-1:0]  handoff_time_i;
  logic                 bus_i;
  logic                 conflict_clr_i;
  logic                 pull_up_en_o;
  logic                 pull_down_en_o;
  logic                 drive_en_o;
  logic                 busy_o;
  logic                 conflict_o;

  modport master (
    output cmd_valid_i, cmd_i, cmd_pp_i, dead_time_i, handoff_time_i,
           bus_i, conflict_clr_i,
    input  cmd_ready_o, pull_up_en_o, pull_down_en_o, drive_en_o,
           busy_o, conflict_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, cmd_pp_i, dead_time_i, handoff_time_i,
           bus_i, conflict_clr_i,
    output cmd_ready_o, pull_up_en_o, pull_down_en_o, drive_en_o,
           busy_o, conflict_o
  );
endinterface

// File: rtl/i3c_sda_drive_ctrl.sv
// i3c_sda_drive_ctrl: sequences pull-up / pull-down enables of one push-pull
// driver cell with break-before-make dead time, open-drain mode and the
// drive-high-then-release handoff used at T-bit / ACK turnaround.
// Optional: define I3C_SDA_DRIVE_CONFLICT_CHECK_EN to flag a driven-high
// line that reads back low (sticky conflict_o). Undefined: conflict_o = 0.
module i3c_sda_drive_ctrl #(
  parameter int DeadTimeW = 4,
  parameter int HandoffW  = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  i3c_sda_drive_ctrl_if.slave   bus_if
);

  localparam logic [1:0] CMD_RELEASE = 2'b00;
  localparam logic [1:0] CMD_LOW     = 2'b01;
  localparam logic [1:0] CMD_HIGH    = 2'b10;
  localparam logic [1:0] CMD_HANDOFF = 2'b11;

  typedef enum logic [2:0] {
    ST_HIZ,
    ST_LOW,
    ST_HIGH,
    ST_DEAD,
    ST_HANDOFF
  } state_t;

  state_t               r_state, w_next_state;
  state_t               r_target, w_next_target;
  logic [DeadTimeW-1:0] r_dead_cnt, w_next_dead_cnt;
  logic [HandoffW-1:0]  r_ho_cnt, w_next_ho_cnt;
  logic                 r_pu, r_pd, r_drive_en, r_ready, r_busy;

  logic                 w_accept;
  logic [1:0]           w_eff_cmd;
  logic                 w_dead_needed;
  logic [HandoffW-1:0]  w_ho_load;

  // Open-drain never drives high: high-type commands collapse to release.
  assign w_eff_cmd = (!bus_if.cmd_pp_i && bus_if.cmd_i[1]) ? CMD_RELEASE : bus_if.cmd_i;
  assign w_accept  = bus_if.cmd_valid_i && r_ready;
  // A zero handoff time still gives one high cycle.
  assign w_ho_load = (bus_if.handoff_time_i == '0) ? HandoffW'(1) : bus_if.handoff_time_i;
  assign w_dead_needed = (bus_if.dead_time_i != '0);

  // State register and registered driver enables, derived from the next state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_HIZ;
      r_target   <= ST_HIZ;
      r_dead_cnt <= '0;
      r_ho_cnt   <= '0;
      r_pu       <= 1'b0;
      r_pd       <= 1'b0;
      r_drive_en <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_target   <= w_next_target;
      r_dead_cnt <= w_next_dead_cnt;
      r_ho_cnt   <= w_next_ho_cnt;
      r_pu       <= (w_next_state == ST_HIGH) || (w_next_state == ST_HANDOFF);
      r_pd       <= (w_next_state == ST_LOW);
      r_drive_en <= (w_next_state == ST_HIGH) || (w_next_state == ST_HANDOFF) ||
                    (w_next_state == ST_LOW);
      r_ready    <= (w_next_state == ST_HIZ) || (w_next_state == ST_LOW) ||
                    (w_next_state == ST_HIGH);
      r_busy     <= (w_next_state == ST_DEAD) || (w_next_state == ST_HANDOFF);
    end
  end

  // Next-state logic: command decode in ready states, countdown in busy states
  always_comb begin
    w_next_state    = r_state;
    w_next_target   = r_target;
    w_next_dead_cnt = r_dead_cnt;
    w_next_ho_cnt   = r_ho_cnt;
    unique case (r_state)
      ST_HIZ, ST_LOW, ST_HIGH: begin
        if (w_accept) begin
          unique case (w_eff_cmd)
            CMD_RELEASE: w_next_state = ST_HIZ;
            CMD_LOW: begin
              if ((r_state == ST_HIGH) && w_dead_needed) begin
                w_next_state    = ST_DEAD;
                w_next_target   = ST_LOW;
                w_next_dead_cnt = bus_if.dead_time_i;
              end else begin
                w_next_state = ST_LOW;
              end
            end
            CMD_HIGH: begin
              if ((r_state == ST_LOW) && w_dead_needed) begin
                w_next_state    = ST_DEAD;
                w_next_target   = ST_HIGH;
                w_next_dead_cnt = bus_if.dead_time_i;
              end else begin
                w_next_state = ST_HIGH;
              end
            end
            CMD_HANDOFF: begin
              if ((r_state == ST_LOW) && w_dead_needed) begin
                w_next_state    = ST_DEAD;
                w_next_target   = ST_HANDOFF;
                w_next_dead_cnt = bus_if.dead_time_i;
              end else begin
                w_next_state  = ST_HANDOFF;
                w_next_ho_cnt = w_ho_load;
              end
            end
            default: w_next_state = ST_HIZ;
          endcase
        end
      end
      ST_DEAD: begin
        if (r_dead_cnt <= DeadTimeW'(1)) begin
          w_next_dead_cnt = '0;
          w_next_state    = r_target;
          if (r_target == ST_HANDOFF) begin
            w_next_ho_cnt = w_ho_load;
          end
        end else begin
          w_next_dead_cnt = r_dead_cnt - DeadTimeW'(1);
        end
      end
      ST_HANDOFF: begin
        if (r_ho_cnt <= HandoffW'(1)) begin
          w_next_ho_cnt = '0;
          w_next_state  = ST_HIZ;
        end else begin
          w_next_ho_cnt = r_ho_cnt - HandoffW'(1);
        end
      end
      default: w_next_state = ST_HIZ;
    endcase
  end

  assign bus_if.pull_up_en_o   = r_pu;
  assign bus_if.pull_down_en_o = r_pd;
  assign bus_if.drive_en_o     = r_drive_en;
  assign bus_if.cmd_ready_o    = r_ready;
  assign bus_if.busy_o         = r_busy;

`ifdef I3C_SDA_DRIVE_CONFLICT_CHECK_EN
  logic r_settled;
  logic r_conflict;

  // Marks the second and later cycles of a state so the line has time to rise
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_settled <= 1'b0;
    end else begin
      r_settled <= (w_next_state == r_state);
    end
  end

  // Sticky conflict flag: clear wins over a same-cycle set
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_conflict <= 1'b0;
    end else if (bus_if.conflict_clr_i) begin
      r_conflict <= 1'b0;
    end else if (((r_state == ST_HIGH) || (r_state == ST_HANDOFF)) &&
                 r_settled && !bus_if.bus_i) begin
      r_conflict <= 1'b1;
    end
  end

  assign bus_if.conflict_o = r_conflict;
`else
  logic w_unused_conflict_inputs;
  assign w_unused_conflict_inputs = bus_if.bus_i ^ bus_if.conflict_clr_i;
  assign bus_if.conflict_o = 1'b0;
`endif

endmodule

// File: tb/tb_i3c_sda_drive_ctrl.sv
// Testbench for i3c_sda_drive_ctrl: vector table, directed multi-cycle
// sequences, and randomized commands against a cycle-list reference model.
module tb_i3c_sda_drive_ctrl;
  localparam int DW = 4;
  localparam int HW = 8;

  localparam logic [1:0] C_REL  = 2'b00;
  localparam logic [1:0] C_LOW  = 2'b01;
  localparam logic [1:0] C_HIGH = 2'b10;
  localparam logic [1:0] C_HO   = 2'b11;

`ifdef I3C_SDA_DRIVE_CONFLICT_CHECK_EN
  localparam logic CONF_EN = 1'b1;
`else
  localparam logic CONF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i3c_sda_drive_ctrl_if #(.DeadTimeW(DW), .HandoffW(HW)) ifc ();

  i3c_sda_drive_ctrl #(.DeadTimeW(DW), .HandoffW(HW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic pu;
    logic pd;
    logic rdy;
    logic busy;
  } out_t;

  localparam out_t O_HIZ  = '{pu: 1'b0, pd: 1'b0, rdy: 1'b1, busy: 1'b0};
  localparam out_t O_LOW  = '{pu: 1'b0, pd: 1'b1, rdy: 1'b1, busy: 1'b0};
  localparam out_t O_HIGH = '{pu: 1'b1, pd: 1'b0, rdy: 1'b1, busy: 1'b0};
  localparam out_t O_DEAD = '{pu: 1'b0, pd: 1'b0, rdy: 1'b0, busy: 1'b1};
  localparam out_t O_HO   = '{pu: 1'b1, pd: 1'b0, rdy: 1'b0, busy: 1'b1};

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [1:0] cmd;
    logic       pp;
    logic [3:0] dt;
    logic [7:0] ht;
    out_t       exp;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input out_t e, input logic econf);
    chk({tag, ".pu"},       ifc.pull_up_en_o,   e.pu);
    chk({tag, ".pd"},       ifc.pull_down_en_o, e.pd);
    chk({tag, ".drive_en"}, ifc.drive_en_o,     e.pu | e.pd);
    chk({tag, ".ready"},    ifc.cmd_ready_o,    e.rdy);
    chk({tag, ".busy"},     ifc.busy_o,         e.busy);
    chk({tag, ".conflict"}, ifc.conflict_o,     econf);
    chk({tag, ".overlap"},  ifc.pull_up_en_o & ifc.pull_down_en_o, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic pp);
    ifc.cmd_valid_i = v;
    ifc.cmd_i       = c;
    ifc.cmd_pp_i    = pp;
  endtask

  // Reference model: the line is a settled level plus a list of
  // per-cycle outputs still owed by the last accepted command.
  int   m_level;   // 0 HIZ, 1 LOW, 2 HIGH
  out_t m_cur;
  out_t m_q [$];

  function automatic out_t steady(input int lvl);
    if (lvl == 1) return O_LOW;
    if (lvl == 2) return O_HIGH;
    return O_HIZ;
  endfunction

  task automatic model_edge();
    logic [1:0] eff;
    int         nho;
    bit         bbm;
    if (!rst_n) begin
      m_level = 0;
      m_q.delete();
      m_cur = O_HIZ;
      return;
    end
    if (!m_cur.rdy) begin
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else m_cur = steady(m_level);
      return;
    end
    if (ifc.cmd_valid_i) begin
      eff = ifc.cmd_i;
      if (!ifc.cmd_pp_i && eff != C_LOW) eff = C_REL;
      bbm = (eff == C_LOW && m_level == 2) ||
            ((eff == C_HIGH || eff == C_HO) && m_level == 1);
      if (bbm) begin
        for (int k = 0; k < int'(ifc.dead_time_i); k++) m_q.push_back(O_DEAD);
      end
      case (eff)
        C_REL:  m_level = 0;
        C_LOW:  m_level = 1;
        C_HIGH: m_level = 2;
        default: begin
          nho = (ifc.handoff_time_i == 0) ? 1 : int'(ifc.handoff_time_i);
          for (int k = 0; k < nho; k++) m_q.push_back(O_HO);
          m_level = 0;
        end
      endcase
    end
    if (m_q.size() > 0) m_cur = m_q.pop_front();
    else m_cur = steady(m_level);
  endtask

  task automatic cyc(input string tag);
    model_edge();
    tick();
    check_outs(tag, m_cur, 1'b0);
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c,
                              input logic pp, input int dt, input int ht, input out_t e);
    vec_t t;
    t.rst_n = r; t.valid = v; t.cmd = c; t.pp = pp;
    t.dt = 4'(dt); t.ht = 8'(ht); t.exp = e;
    return t;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    ifc.cmd_valid_i    = 1'b0;
    ifc.cmd_i          = C_REL;
    ifc.cmd_pp_i       = 1'b1;
    ifc.dead_time_i    = '0;
    ifc.handoff_time_i = '0;
    ifc.bus_i          = 1'b1;
    ifc.conflict_clr_i = 1'b0;

    // rst, valid, cmd, pp, dead, handoff, expected after the edge
    tbl[0]  = mk(0, 1, C_HIGH, 1, 3, 2, O_HIZ);
    tbl[1]  = mk(0, 1, C_HIGH, 1, 3, 2, O_HIZ);
    tbl[2]  = mk(0, 1, C_HIGH, 1, 3, 2, O_HIZ);
    tbl[3]  = mk(1, 1, C_HIGH, 1, 3, 2, O_HIGH);
    tbl[4]  = mk(1, 0, C_HIGH, 1, 3, 2, O_HIGH);
    tbl[5]  = mk(1, 1, C_LOW,  1, 3, 2, O_DEAD);
    tbl[6]  = mk(1, 1, C_REL,  1, 3, 2, O_DEAD);
    tbl[7]  = mk(1, 1, C_REL,  1, 3, 2, O_DEAD);
    tbl[8]  = mk(1, 1, C_REL,  1, 3, 2, O_LOW);
    tbl[9]  = mk(1, 1, C_REL,  1, 3, 2, O_HIZ);
    tbl[10] = mk(1, 1, C_LOW,  1, 3, 2, O_LOW);
    tbl[11] = mk(1, 1, C_HIGH, 1, 0, 2, O_HIGH);
    tbl[12] = mk(1, 1, C_HIGH, 1, 0, 2, O_HIGH);
    tbl[13] = mk(1, 1, C_HO,   1, 0, 0, O_HO);
    tbl[14] = mk(1, 0, C_REL,  1, 0, 0, O_HIZ);
    tbl[15] = mk(1, 1, C_LOW,  1, 3, 0, O_LOW);
    tbl[16] = mk(1, 1, C_HIGH, 0, 3, 0, O_HIZ);
    tbl[17] = mk(1, 1, C_LOW,  0, 3, 0, O_LOW);
    tbl[18] = mk(1, 1, C_HO,   0, 3, 0, O_HIZ);
    tbl[19] = mk(1, 1, C_LOW,  1, 2, 2, O_LOW);
    tbl[20] = mk(1, 1, C_HO,   1, 2, 2, O_DEAD);
    tbl[21] = mk(1, 0, C_HO,   1, 2, 2, O_DEAD);
    tbl[22] = mk(1, 0, C_HO,   1, 2, 2, O_HO);
    tbl[23] = mk(1, 0, C_HO,   1, 2, 2, O_HO);
    tbl[24] = mk(1, 0, C_HO,   1, 2, 2, O_HIZ);

    for (int i = 0; i < 25; i++) begin
      rst_n = tbl[i].rst_n;
      drive(tbl[i].valid, tbl[i].cmd, tbl[i].pp);
      ifc.dead_time_i    = tbl[i].dt;
      ifc.handoff_time_i = tbl[i].ht;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].exp, 1'b0);
    end

    // Handoff of 5 cycles from HIGH, next command taken in the first HIZ cycle
    ifc.dead_time_i = 4'd0;
    ifc.handoff_time_i = 8'd5;
    drive(1, C_HIGH, 1); tick(); check_outs("ho5.high", O_HIGH, 1'b0);
    drive(1, C_HO, 1);   tick(); check_outs("ho5.c1", O_HO, 1'b0);
    drive(0, C_HO, 1);
    for (int k = 2; k <= 5; k++) begin
      tick(); check_outs($sformatf("ho5.c%0d", k), O_HO, 1'b0);
    end
    tick(); check_outs("ho5.release", O_HIZ, 1'b0);
    drive(1, C_LOW, 1); tick(); check_outs("ho5.next_cmd", O_LOW, 1'b0);

    // Reset in the middle of a long dead time: pending HIGH is dropped
    ifc.dead_time_i = 4'd10;
    drive(1, C_HIGH, 1); tick(); check_outs("rstdead.enter", O_DEAD, 1'b0);
    drive(0, C_REL, 1);
    for (int k = 0; k < 5; k++) begin
      tick(); check_outs($sformatf("rstdead.d%0d", k), O_DEAD, 1'b0);
    end
    rst_n = 1'b0; tick(); check_outs("rstdead.reset", O_HIZ, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(); check_outs($sformatf("rstdead.idle%0d", k), O_HIZ, 1'b0);
    end

    // Conflict detection while driving high
    ifc.dead_time_i = 4'd0;
    drive(1, C_HIGH, 1); ifc.bus_i = 1'b1;
    tick(); check_outs("conf.high", O_HIGH, 1'b0);
    drive(0, C_HIGH, 1); ifc.bus_i = 1'b0;
    tick(); check_outs("conf.first_cycle", O_HIGH, 1'b0);
    tick(); check_outs("conf.set", O_HIGH, CONF_EN);
    ifc.bus_i = 1'b1;
    tick(); check_outs("conf.hold", O_HIGH, CONF_EN);
    ifc.conflict_clr_i = 1'b1;
    tick(); check_outs("conf.clear", O_HIGH, 1'b0);
    ifc.conflict_clr_i = 1'b0;
    drive(1, C_REL, 1);
    tick(); check_outs("conf.release", O_HIZ, 1'b0);

    // Randomized commands against the reference model
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin ifc.dead_time_i = 4'd0;  ifc.handoff_time_i = 8'd0; end
        1: begin ifc.dead_time_i = 4'd3;  ifc.handoff_time_i = 8'd5; end
        2: begin ifc.dead_time_i = 4'd1;  ifc.handoff_time_i = 8'd1; end
        default: begin ifc.dead_time_i = 4'd15; ifc.handoff_time_i = 8'd2; end
      endcase
      rst_n = 1'b0; drive(1, C_HIGH, 1);
      cyc("rnd.reset0"); cyc("rnd.reset1");
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
        drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 8));
        ifc.conflict_clr_i = 1'($urandom_range(0, 1));
        cyc($sformatf("rnd%0d.%0d", s, k));
      end
    end

    // Open-drain: 1000 random commands, pull-up must never turn on
    ifc.dead_time_i = 4'd3;
    ifc.handoff_time_i = 8'd5;
    rst_n = 1'b0; drive(0, C_REL, 0);
    cyc("od.reset");
    rst_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      cyc($sformatf("od.%0d", k));
      chk("od.pu_off", ifc.pull_up_en_o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
